// File: rtl/c3lib_tie_bus_mon_lcell_if.sv
// Tie/strap monitor bus: raw tie inputs and control pulses in, qualified value and status out.
interface c3lib_tie_bus_mon_lcell_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_bus;
  logic             sample_req;
  logic             clr_sticky;
  logic [WIDTH-1:0] bus_val;
  logic             valid;
  logic             mismatch;
  logic             change_sticky;

  modport master (
    output in_bus, sample_req, clr_sticky,
    input  bus_val, valid, mismatch, change_sticky
  );

  modport slave (
    input  in_bus, sample_req, clr_sticky,
    output bus_val, valid, mismatch, change_sticky
  );
endinterface

// File: rtl/c3lib_tie_bus_mon_lcell.sv
// Synchronizes a static tie bus, locks it after STABLE_CYCLES equal samples,
// flags mismatch against EXPECT_VALUE and tracks post-lock changes (all outputs registered).
module c3lib_tie_bus_mon_lcell #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] EXPECT_VALUE  = WIDTH'(3),
  parameter int               STABLE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  c3lib_tie_bus_mon_lcell_if.slave     mon
);
  localparam int             CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {ACQ, LOCK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q1, s, p;
  logic [2:0]       prime;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] bus_val_r;
  logic             valid_r, mismatch_r, sticky_r;
  logic             lock_hit, changed;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lock_hit  = 1'b0;
    changed   = 1'b0;
    unique case (state)
      ACQ: begin
        // p only carries real bus data once the prime shifter has filled.
        if (prime[2]) begin
          if (s != p) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_MAX) begin
            lock_hit  = 1'b1;
            state_nxt = LOCK;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOCK: begin
        changed = (s != bus_val_r);
      end
      default: state_nxt = ACQ;
    endcase
    // Re-acquire request overrides a coincident lock and any change detection.
    if (mon.sample_req) begin
      state_nxt = ACQ;
      cnt_nxt   = '0;
      lock_hit  = 1'b0;
      changed   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACQ;
      q1         <= '0;
      s          <= '0;
      p          <= '0;
      prime      <= '0;
      cnt        <= '0;
      bus_val_r  <= '0;
      valid_r    <= 1'b0;
      mismatch_r <= 1'b0;
      sticky_r   <= 1'b0;
    end else begin
      q1    <= mon.in_bus;
      s     <= q1;
      p     <= s;
      prime <= {prime[1:0], 1'b1};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mon.sample_req) begin
        valid_r    <= 1'b0;
        mismatch_r <= 1'b0;
      end else if (lock_hit) begin
        bus_val_r  <= s;
        valid_r    <= 1'b1;
        mismatch_r <= (s != EXPECT_VALUE);
      end
      // A fresh change beats a coincident clear.
      if (changed) begin
        sticky_r <= 1'b1;
      end else if (mon.clr_sticky) begin
        sticky_r <= 1'b0;
      end
    end
  end

  assign mon.bus_val       = bus_val_r;
  assign mon.valid         = valid_r;
  assign mon.mismatch      = mismatch_r;
  assign mon.change_sticky = sticky_r;
endmodule

// File: tb/tb_c3lib_tie_bus_mon_lcell.sv
// Bench for the tie bus monitor: directed scenarios plus random traffic against a window-based model.
module tb_c3lib_tie_bus_mon_lcell;
  localparam logic [3:0] EXP = 4'b0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c3lib_tie_bus_mon_lcell_if #(.WIDTH(4)) bus_if ();

  c3lib_tie_bus_mon_lcell #(
    .WIDTH(4), .EXPECT_VALUE(EXP), .STABLE_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus_if.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: edge index since reset release and a history of sampled bus values.
  int         e;
  int         acq_start;
  logic [3:0] hist[$];
  bit         m_locked, m_valid, m_mis, m_sticky;
  logic [3:0] m_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, e, $time);
    end
  endtask

  function automatic void model_reset();
    e = 0;
    acq_start = 4;
    hist.delete();
    m_locked = 0; m_valid = 0; m_mis = 0; m_sticky = 0; m_val = '0;
  endfunction

  // Lock rule: the last STABLE_CYCLES compares (s vs its predecessor) were all equal,
  // all of them taken since acquisition began.
  function automatic void model_step(input logic rst, input logic [3:0] in_v,
                                     input logic sreq, input logic clr);
    logic [3:0] sv;
    bit         win_ok;
    bit         set_st;
    if (!rst) begin
      model_reset();
      return;
    end
    e++;
    hist.push_front(in_v);
    if (hist.size() > 12) void'(hist.pop_back());
    sv = (hist.size() > 2) ? hist[2] : 4'h0;
    win_ok = 0;
    if (!m_locked && e >= acq_start + 7 && hist.size() >= 11) begin
      win_ok = 1;
      for (int j = 3; j <= 10; j++) if (hist[j] != hist[2]) win_ok = 0;
    end
    set_st = m_locked && !sreq && (sv != m_val);
    if (set_st) m_sticky = 1;
    else if (clr) m_sticky = 0;
    if (sreq) begin
      m_locked = 0; m_valid = 0; m_mis = 0;
      acq_start = (e + 1 > 4) ? e + 1 : 4;
    end else if (win_ok) begin
      m_locked = 1; m_valid = 1; m_val = sv; m_mis = (sv != EXP);
    end
  endfunction

  task automatic tick();
    logic       r, sq, cl;
    logic [3:0] iv;
    @(posedge clk);
    r = rst_n; iv = bus_if.in_bus; sq = bus_if.sample_req; cl = bus_if.clr_sticky;
    model_step(r, iv, sq, cl);
    #1;
    chk("valid",    32'(bus_if.valid),         32'(m_valid));
    chk("bus_val",  32'(bus_if.bus_val),       32'(m_val));
    chk("mismatch", 32'(bus_if.mismatch),      32'(m_mis));
    chk("sticky",   32'(bus_if.change_sticky), 32'(m_sticky));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.sample_req = 1'b0;
    bus_if.clr_sticky = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] stable_v;

  initial begin
    model_reset();
    bus_if.in_bus = 4'h0;
    bus_if.sample_req = 1'b0;
    bus_if.clr_sticky = 1'b0;
    tick();
    do_reset();
    chk("rst_valid", 32'(bus_if.valid), 32'd0);
    chk("rst_bus_val", 32'(bus_if.bus_val), 32'd0);

    // Expected tie held from reset release: lock exactly at edge 11.
    bus_if.in_bus = 4'b0011;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) chk("s1_valid_e10", 32'(bus_if.valid), 32'd0);
    end
    chk("s1_valid_e11", 32'(bus_if.valid), 32'd1);
    chk("s1_bus_val", 32'(bus_if.bus_val), 32'h3);
    chk("s1_mismatch", 32'(bus_if.mismatch), 32'd0);

    // Post-lock change sets sticky; clear loses to an ongoing change.
    bus_if.in_bus = 4'b1111;
    repeat (3) tick();
    chk("s4_sticky", 32'(bus_if.change_sticky), 32'd1);
    chk("s4_bus_val", 32'(bus_if.bus_val), 32'h3);
    chk("s4_valid", 32'(bus_if.valid), 32'd1);
    bus_if.clr_sticky = 1'b1;
    tick();
    bus_if.clr_sticky = 1'b0;
    chk("s4_set_wins", 32'(bus_if.change_sticky), 32'd1);

    // Re-acquire request in LOCK: relock 8 edges later on the new value.
    bus_if.sample_req = 1'b1;
    tick();
    bus_if.sample_req = 1'b0;
    chk("s5_valid_k", 32'(bus_if.valid), 32'd0);
    repeat (7) tick();
    chk("s5_valid_k7", 32'(bus_if.valid), 32'd0);
    tick();
    chk("s5_valid_k8", 32'(bus_if.valid), 32'd1);
    chk("s5_bus_val", 32'(bus_if.bus_val), 32'hF);
    chk("s5_mismatch", 32'(bus_if.mismatch), 32'd1);

    // Reset in LOCK, then a non-expected tie value.
    do_reset();
    chk("s6_valid", 32'(bus_if.valid), 32'd0);
    chk("s6_sticky", 32'(bus_if.change_sticky), 32'd0);
    chk("s6_bus_val", 32'(bus_if.bus_val), 32'd0);
    bus_if.in_bus = 4'b0101;
    repeat (10) tick();
    chk("s2_valid_e10", 32'(bus_if.valid), 32'd0);
    tick();
    chk("s2_valid_e11", 32'(bus_if.valid), 32'd1);
    chk("s2_bus_val", 32'(bus_if.bus_val), 32'h5);
    chk("s2_mismatch", 32'(bus_if.mismatch), 32'd1);

    // One-cycle glitch during acquisition delays the lock.
    do_reset();
    bus_if.in_bus = 4'b0011;
    for (int i = 1; i <= 25; i++) begin
      bus_if.in_bus = (i == 7) ? 4'b0111 : 4'b0011;
      tick();
      if (i == 11) chk("s3_valid_e11", 32'(bus_if.valid), 32'd0);
    end
    chk("s3_valid_late", 32'(bus_if.valid), 32'd1);
    chk("s3_bus_val", 32'(bus_if.bus_val), 32'h3);

    // Random traffic against the model.
    stable_v = 4'b0011;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        stable_v = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'($urandom);
      bus_if.in_bus     = ($urandom_range(0, 29) == 0) ? 4'($urandom) : stable_v;
      bus_if.sample_req = ($urandom_range(0, 59) == 0);
      bus_if.clr_sticky = ($urandom_range(0, 19) == 0);
      rst_n             = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus_if.sample_req = 1'b0;
    bus_if.clr_sticky = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
